// File: rtl/hazard_scheduler.sv
// Stall/forward controller tracking in-flight producers through E, M and W.
// Optional stall counter port HZS_o_StallCnt enabled by defining HZS_STALL_CNT_EN.
module hazard_scheduler #(
  parameter int TW    = 4,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    HZS_i_Rs,
  input  logic [4:0]    HZS_i_Rt,
  input  logic [TW-1:0] HZS_i_TuseRs,
  input  logic [TW-1:0] HZS_i_TuseRt,
  input  logic [TW-1:0] HZS_i_TnewD,
  input  logic [4:0]    HZS_i_WAddr,
  output logic          HZS_o_Stall,
  output logic [1:0]    HZS_o_FwdDRs,
  output logic [1:0]    HZS_o_FwdDRt,
  output logic [1:0]    HZS_o_FwdERs,
  output logic [1:0]    HZS_o_FwdERt,
`ifdef HZS_STALL_CNT_EN
  output logic [CNT_W-1:0] HZS_o_StallCnt,
`endif
  output logic          HZS_o_FwdMRt
);

  localparam logic [TW-1:0] NEVER = {TW{1'b1}};
  localparam logic [TW-1:0] ZERO  = '0;

  logic [4:0]    e_addr_q, e_addr_d;
  logic [4:0]    e_rs_q, e_rs_d;
  logic [4:0]    e_rt_q, e_rt_d;
  logic [TW-1:0] e_tnew_q, e_tnew_d;
  logic [4:0]    m_addr_q, m_addr_d;
  logic [4:0]    m_rt_q, m_rt_d;
  logic [TW-1:0] m_tnew_q, m_tnew_d;
  logic [4:0]    w_addr_q, w_addr_d;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x == ZERO) ? ZERO : x - {{(TW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic hz(
    input logic [4:0]    op,
    input logic [TW-1:0] tuse,
    input logic [4:0]    addr,
    input logic [TW-1:0] tnew
  );
    return (op != 5'd0) && (op == addr) &&
           (tuse != NEVER) && (tnew > tuse);
  endfunction

  // Youngest match wins; a not-yet-ready youngest match hides older ones.
  function automatic logic [1:0] fwd_d(
    input logic [4:0]    op,
    input logic [TW-1:0] tuse,
    input logic [4:0]    ea,
    input logic [TW-1:0] et,
    input logic [4:0]    ma,
    input logic [TW-1:0] mt,
    input logic [4:0]    wa
  );
    logic [1:0] r;
    r = 2'd0;
    if (op == 5'd0 || tuse == NEVER) r = 2'd0;
    else if (op == ea) r = (et == ZERO) ? 2'd1 : 2'd0;
    else if (op == ma) r = (mt == ZERO) ? 2'd2 : 2'd0;
    else if (op == wa) r = 2'd3;
    return r;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [4:0]    op,
    input logic [4:0]    ma,
    input logic [TW-1:0] mt,
    input logic [4:0]    wa
  );
    logic [1:0] r;
    r = 2'd0;
    if (op == 5'd0) r = 2'd0;
    else if (op == ma && mt == ZERO) r = 2'd2;
    else if (op == wa) r = 2'd3;
    return r;
  endfunction

  always_comb begin
    HZS_o_Stall =
      hz(HZS_i_Rs, HZS_i_TuseRs, e_addr_q, e_tnew_q) ||
      hz(HZS_i_Rt, HZS_i_TuseRt, e_addr_q, e_tnew_q) ||
      hz(HZS_i_Rs, HZS_i_TuseRs, m_addr_q, m_tnew_q) ||
      hz(HZS_i_Rt, HZS_i_TuseRt, m_addr_q, m_tnew_q);
    HZS_o_FwdDRs = fwd_d(HZS_i_Rs, HZS_i_TuseRs, e_addr_q,
                         e_tnew_q, m_addr_q, m_tnew_q, w_addr_q);
    HZS_o_FwdDRt = fwd_d(HZS_i_Rt, HZS_i_TuseRt, e_addr_q,
                         e_tnew_q, m_addr_q, m_tnew_q, w_addr_q);
    HZS_o_FwdERs = fwd_e(e_rs_q, m_addr_q, m_tnew_q, w_addr_q);
    HZS_o_FwdERt = fwd_e(e_rt_q, m_addr_q, m_tnew_q, w_addr_q);
    HZS_o_FwdMRt = (m_rt_q != 5'd0) && (m_rt_q == w_addr_q);
  end

  always_comb begin
    e_addr_d = 5'd0;
    e_rs_d   = 5'd0;
    e_rt_d   = 5'd0;
    e_tnew_d = ZERO;
    if (!HZS_o_Stall) begin
      e_addr_d = (HZS_i_TnewD == ZERO) ? 5'd0 : HZS_i_WAddr;
      e_rs_d   = HZS_i_Rs;
      e_rt_d   = HZS_i_Rt;
      e_tnew_d = sat_dec(HZS_i_TnewD);
    end
    m_addr_d = e_addr_q;
    m_rt_d   = e_rt_q;
    m_tnew_d = sat_dec(e_tnew_q);
    w_addr_d = m_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_addr_q <= 5'd0;
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_tnew_q <= ZERO;
      m_addr_q <= 5'd0;
      m_rt_q   <= 5'd0;
      m_tnew_q <= ZERO;
      w_addr_q <= 5'd0;
    end else begin
      e_addr_q <= e_addr_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_tnew_q <= e_tnew_d;
      m_addr_q <= m_addr_d;
      m_rt_q   <= m_rt_d;
      m_tnew_q <= m_tnew_d;
      w_addr_q <= w_addr_d;
    end
  end

`ifdef HZS_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (HZS_o_Stall) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign HZS_o_StallCnt = cnt_q;
`endif

endmodule
